// File: rtl/imem_prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_prog_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - loader FSM state encoding
//   - byte/word geometry of the incoming program stream
//   - small helper predicates used by the FSM
// No ports (package).
// -----------------------------------------------------------------------------
package imem_prog_loader_pkg;

  // Geometry of one instruction word as seen by the byte stream.
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  // Loader phases. INIT is a single settling cycle before bytes are taken.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  // A reload request is only honoured once the loader has settled,
  // either with a running core or after an overflow.
  function automatic logic reload_allowed(input loader_state_t st);
    return (st == ST_RUN) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_prog_loader_if.sv
// -----------------------------------------------------------------------------
// imem_prog_loader_if
// Byte-stream handshake between a program source (host/bench) and the loader.
// Signals:
//   in_valid  source presents a byte
//   in_data   program byte
//   in_last   final byte of the image
//   in_ready  loader accepts the byte this cycle
// Modports:
//   master  the byte source
//   slave   the loader
// -----------------------------------------------------------------------------
interface imem_prog_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/imem_prog_loader_packer.sv
// -----------------------------------------------------------------------------
// imem_prog_loader_packer
// Assembles program bytes little-endian into one 32-bit word.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low
//   clear    empty the packer: all lanes zero, index back to lane 0
//   load     write byte_in into the current lane and advance the index
//   byte_in  incoming program byte
//   last_in  the incoming byte is the final byte of the image
//   word     assembled word (lane 0 = bits 7:0); unfilled lanes read zero
//   full     the current lane is the top lane, so a load now completes a word
//   last     the most recently loaded byte carried in_last
// -----------------------------------------------------------------------------
module imem_prog_loader_packer
  import imem_prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              last_in,
  output logic [WORD_W-1:0] word,
  output logic              full,
  output logic              last
);

  logic [IDX_W-1:0]                   idx;
  logic [WORD_BYTES-1:0][BYTE_W-1:0]  lanes;

  // Lanes are zeroed on clear so that a short final word comes out
  // zero padded without any extra masking at write time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      lanes <= '0;
      last  <= 1'b0;
    end else if (clear) begin
      idx   <= '0;
      lanes <= '0;
      last  <= 1'b0;
    end else if (load) begin
      lanes[idx] <= byte_in;
      idx        <= idx + 1'b1;
      last       <= last_in;
    end
  end

  assign word = lanes;
  assign full = (idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_prog_loader.sv
// -----------------------------------------------------------------------------
// imem_prog_loader
// Writes a program image into instruction memory from a byte stream while
// holding the processor in reset; releases the core once the image is in.
// Parameters:
//   ADDR_W     instruction-memory word-address width
//   MAX_WORDS  maximum words accepted (must be <= 2**ADDR_W)
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low
//   bus           byte-stream handshake (slave side)
//   reload        single-cycle pulse; restarts loading from RUN or ERROR
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word address of the write
//   imem_wdata    assembled word
//   core_reset    active-high hold to processor reset
//   done          image loaded, core running
//   err_overflow  sticky, image exceeded MAX_WORDS
//   word_count    words written since the last load start
// All outputs are registered.
// -----------------------------------------------------------------------------
module imem_prog_loader
  import imem_prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_prog_loader_if.slave    bus,
  input  logic                 reload,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [WORD_W-1:0]    imem_wdata,
  output logic                 core_reset,
  output logic                 done,
  output logic                 err_overflow,
  output logic [ADDR_W:0]      word_count
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);

  loader_state_t        state, state_next;
  logic                 in_ready_q, in_ready_next;
  logic                 imem_we_next;
  logic [ADDR_W-1:0]    imem_addr_next;
  logic [WORD_W-1:0]    imem_wdata_next;
  logic                 core_reset_next;
  logic                 done_next;
  logic                 err_next;
  logic [ADDR_W:0]      count_next;

  logic                 accept;
  logic                 pk_clear;
  logic                 pk_load;
  logic [WORD_W-1:0]    pk_word;
  logic                 pk_full;
  logic                 pk_last;

  assign bus.in_ready = in_ready_q;
  assign accept       = bus.in_valid & in_ready_q;

  imem_prog_loader_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .clear   (pk_clear),
    .load    (pk_load),
    .byte_in (bus.in_data),
    .last_in (bus.in_last),
    .word    (pk_word),
    .full    (pk_full),
    .last    (pk_last)
  );

  // State and every output are registered here; the next values all come
  // from the combinational block below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_INIT;
      in_ready_q   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      word_count   <= '0;
    end else begin
      state        <= state_next;
      in_ready_q   <= in_ready_next;
      imem_we      <= imem_we_next;
      imem_addr    <= imem_addr_next;
      imem_wdata   <= imem_wdata_next;
      core_reset   <= core_reset_next;
      done         <= done_next;
      err_overflow <= err_next;
      word_count   <= count_next;
    end
  end

  // Next-state and next-output logic. A word takes four LOAD cycles plus one
  // WRITE cycle, so in_ready drops for exactly the WRITE cycle. The memory
  // write is registered on the way out of WRITE, after the last byte has
  // landed in the packer.
  always_comb begin
    state_next      = state;
    in_ready_next   = in_ready_q;
    imem_we_next    = 1'b0;
    imem_addr_next  = imem_addr;
    imem_wdata_next = imem_wdata;
    core_reset_next = core_reset;
    done_next       = done;
    err_next        = err_overflow;
    count_next      = word_count;
    pk_clear        = 1'b0;
    pk_load         = 1'b0;

    case (state)
      ST_INIT: begin
        state_next      = ST_LOAD;
        in_ready_next   = (word_count != MAX_CNT);
        core_reset_next = 1'b1;
        done_next       = 1'b0;
        pk_clear        = 1'b1;
      end

      ST_LOAD: begin
        if (accept) begin
          pk_load = 1'b1;
          if (pk_full || bus.in_last) begin
            in_ready_next = 1'b0;
            state_next    = ST_WRITE;
          end
        end else if (bus.in_valid && (word_count == MAX_CNT)) begin
          // in_ready is already low here: the image is full and the source
          // still has data, so this is an overflow rather than a stall.
          in_ready_next = 1'b0;
          err_next      = 1'b1;
          state_next    = ST_ERROR;
        end
      end

      ST_WRITE: begin
        imem_we_next    = 1'b1;
        imem_addr_next  = word_count[ADDR_W-1:0];
        imem_wdata_next = pk_word;
        count_next      = word_count + 1'b1;
        pk_clear        = 1'b1;
        if (pk_last) begin
          state_next      = ST_RUN;
          in_ready_next   = 1'b0;
          core_reset_next = 1'b0;
          done_next       = 1'b1;
        end else begin
          state_next    = ST_LOAD;
          in_ready_next = ((word_count + 1'b1) != MAX_CNT);
        end
      end

      ST_RUN, ST_ERROR: begin
        in_ready_next = 1'b0;
        if (reload && reload_allowed(state)) begin
          state_next      = ST_INIT;
          core_reset_next = 1'b1;
          done_next       = 1'b0;
          err_next        = 1'b0;
          count_next      = '0;
        end
      end

      default: begin
        state_next      = ST_INIT;
        in_ready_next   = 1'b0;
        core_reset_next = 1'b1;
        done_next       = 1'b0;
      end
    endcase
  end

endmodule
